cell_sweep_sequencer: RTL

//   Schedules the shared cell memory: one generation = read sweep, then write sweep, then buffer swap.

---
 rtl/game_pkg.sv | 29 ++
 rtl/sweep_addr_counter.sv | 39 +++
 rtl/cell_sweep_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the cell sweep sequencer: state encodings and default sizing.
package game_pkg;

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_LOAD  = 3'b001;
    localparam logic [2:0] ST_READ  = 3'b010;
    localparam logic [2:0] ST_WRITE = 3'b011;
    localparam logic [2:0] ST_SWAP  = 3'b100;
    localparam logic [2:0] ST_HOLD  = 3'b101;
    localparam logic [2:0] ST_WIN   = 3'b110;
    localparam logic [2:0] ST_LOSE  = 3'b111;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StLoad  = ST_LOAD,
        StRead  = ST_READ,
        StWrite = ST_WRITE,
        StSwap  = ST_SWAP,
        StHold  = ST_HOLD,
        StWin   = ST_WIN,
        StLose  = ST_LOSE
    } state_e;

    localparam int unsigned DefCells   = 256;
    localparam int unsigned DefAddrW   = 8;
    localparam int unsigned DefGenW    = 15;
    localparam int unsigned DefWinGens = 50;

endpackage

// File: rtl/sweep_addr_counter.sv
// Cell address counter for one sweep; wraps to 0 after the last cell so the
// read sweep hands over to the write sweep already pointing at address 0.
module sweep_addr_counter
    import game_pkg::*;
#(
    parameter int unsigned CELLS  = DefCells,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last = (addr_q == ADDR_W'(CELLS - 1));
    assign addr = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
        end else if (inc) begin
            addr_d = last ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/cell_sweep_sequencer.sv
// Generation scheduler for the shared cell RAM: read sweep, write sweep, buffer swap,
// with loader arbitration, generation counting and sticky win/lose flags.
module cell_sweep_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CELLS    = DefCells,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned GEN_W    = DefGenW,
    parameter int unsigned WIN_GENS = DefWinGens
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              run,
    input  logic              hold,
    input  logic              load_req,
    input  logic              lose_sig,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              buf_swap,
    output logic              load_grant,
    output logic [GEN_W-1:0]  gen_count,
    output logic              win,
    output logic              lose,
    output logic [2:0]        state
);

    state_e           state_q, state_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             pend_q, pend_d;
    logic             in_sweep;
    logic             addr_clr;
    logic             addr_inc;
    logic             addr_last;
    logic [GEN_W:0]   gen_plus1;

    assign in_sweep  = (state_q == StRead) || (state_q == StWrite);
    // Address only moves inside a sweep; anywhere else it is parked at 0.
    assign addr_clr  = load_req || !in_sweep;
    assign addr_inc  = in_sweep && mem_ack && !load_req;
    assign gen_plus1 = {1'b0, gen_q} + 1'b1;

    sweep_addr_counter #(
        .CELLS  (CELLS),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clka (clka),
        .rst  (rst),
        .clr  (addr_clr),
        .inc  (addr_inc),
        .last (addr_last),
        .addr (mem_addr)
    );

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        win_d   = win_q | (state_q == StWin);
        lose_d  = lose_q | (state_q == StLose);
        pend_d  = pend_q;
        if (load_req) begin
            state_d = StLoad;
        end else begin
            case (state_q)
                StLoad: begin
                    state_d = StIdle;
                    gen_d   = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    pend_d  = 1'b0;
                end
                StIdle: begin
                    if (lose_sig)         state_d = StLose;
                    else if (run && hold) state_d = StHold;
                    else if (run)         state_d = StRead;
                end
                StHold: begin
                    if (lose_sig)           state_d = StLose;
                    else if (!hold || !run) state_d = StIdle;
                end
                StRead, StWrite: begin
                    if (lose_sig) pend_d = 1'b1;
                    if (mem_ack && addr_last) begin
                        state_d = (state_q == StRead) ? StWrite : StSwap;
                    end
                end
                StSwap: begin
                    if (gen_q != '1) gen_d = gen_q + 1'b1;
                    pend_d = 1'b0;
                    if (pend_q || lose_sig)                       state_d = StLose;
                    else if (gen_plus1 == (GEN_W+1)'(WIN_GENS)) state_d = StWin;
                    else                                          state_d = StIdle;
                end
                StWin, StLose: state_d = state_q;
                default:       state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= StIdle;
            gen_q   <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            pend_q  <= pend_d;
        end
    end

    assign mem_rd     = (state_q == StRead);
    assign mem_wr     = (state_q == StWrite);
    assign buf_swap   = (state_q == StSwap);
    assign load_grant = (state_q == StLoad);
    assign gen_count  = gen_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign state      = state_q;

endmodule
